// File: rtl/stopwatch_pkg.sv
// Shared run-state encodings and command priority for the stopwatch control path.
// Used by stopwatch_input_ctrl and the run-state FSM.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  typedef enum logic [1:0] {
    CmdNone,
    CmdStart,
    CmdStop,
    CmdClear
  } cmd_e;

  // Priority order clear > stop > start; lower-priority requests are dropped.
  function automatic cmd_e arbitrate(input logic clr_req, input logic stop_req,
                                     input logic start_req);
    cmd_e cmd;
    cmd = CmdNone;
    if (clr_req) begin
      cmd = CmdClear;
    end else if (stop_req) begin
      cmd = CmdStop;
    end else if (start_req) begin
      cmd = CmdStart;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counting debouncer for one push-button.
// rise_o is a registered one-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw_i;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      deb_d  = sync2_q;
      cnt_d  = '0;
      rise_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = deb_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/stopwatch_input_ctrl.sv
// Button front-end: debounce, state filter, arbitration and lockout for stopwatch commands.
// Define LONG_PRESS_CLEAR_EN to let a long stop hold raise a clear request.
module stopwatch_input_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 16,
  parameter int unsigned LOCKOUT_CYCLES    = 4,
  parameter int unsigned LONG_PRESS_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_raw,
  input  logic       btn_stop_raw,
  input  logic       btn_clear_raw,
  input  logic [1:0] run_state,
  output logic       start_o,
  output logic       stop_o,
  output logic       clear_o,
  output logic       busy
);

  localparam int unsigned LW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

  logic start_rise, stop_rise, clr_rise;
  logic start_level, stop_level, clr_level;
  logic lp_req;
  logic running;
  cmd_e cmd;

  logic          start_q, start_d;
  logic          stop_q, stop_d;
  logic          clear_q, clear_d;
  logic          busy_q, busy_d;
  logic [LW-1:0] lock_q, lock_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk      (clk),
    .reset    (reset),
    .btn_raw_i(btn_start_raw),
    .level_o  (start_level),
    .rise_o   (start_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
    .clk      (clk),
    .reset    (reset),
    .btn_raw_i(btn_stop_raw),
    .level_o  (stop_level),
    .rise_o   (stop_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk      (clk),
    .reset    (reset),
    .btn_raw_i(btn_clear_raw),
    .level_o  (clr_level),
    .rise_o   (clr_rise)
  );

`ifdef LONG_PRESS_CLEAR_EN
  localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          unused_levels;

  // Saturating hold counter fires the request exactly once per stop press.
  always_comb begin
    hold_d = hold_q;
    lp_req = 1'b0;
    if (!stop_level) begin
      hold_d = '0;
    end else if (hold_q != HW'(LONG_PRESS_CYCLES)) begin
      hold_d = hold_q + 1'b1;
      lp_req = (hold_q == HW'(LONG_PRESS_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign unused_levels = start_level ^ clr_level;
`else
  logic unused_levels;

  assign lp_req        = 1'b0;
  assign unused_levels = start_level ^ stop_level ^ clr_level ^ (LONG_PRESS_CYCLES != 0);
`endif

  always_comb begin
    running = (run_state == ST_RUN);
    cmd     = CmdNone;
    if (lock_q == '0) begin
      cmd = arbitrate((clr_rise | lp_req) & ~running, stop_rise & running,
                      start_rise & ~running);
    end
    start_d = (cmd == CmdStart);
    stop_d  = (cmd == CmdStop);
    clear_d = (cmd == CmdClear);
    lock_d  = lock_q;
    if (cmd != CmdNone) begin
      lock_d = LW'(LOCKOUT_CYCLES);
    end else if (lock_q != '0) begin
      lock_d = lock_q - 1'b1;
    end
    busy_d = (lock_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      lock_q  <= '0;
    end else begin
      start_q <= start_d;
      stop_q  <= stop_d;
      clear_q <= clear_d;
      busy_q  <= busy_d;
      lock_q  <= lock_d;
    end
  end

  assign start_o = start_q;
  assign stop_o  = stop_q;
  assign clear_o = clear_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_stopwatch_input_ctrl.sv
// Randomised bench: a window-based button model predicts command pulses into a scoreboard
// queue; a negedge monitor pops and compares whenever the DUT emits a pulse.
module tb_stopwatch_input_ctrl;

  localparam int D    = 16;
  localparam int LOCK = 4;
  localparam int LONG = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bs = 1'b0, bp = 1'b0, bc = 1'b0;
  logic [1:0] rs = 2'b00;
  logic       start_o, stop_o, clear_o, busy;

  stopwatch_input_ctrl #(
    .DEBOUNCE_CYCLES  (D),
    .LOCKOUT_CYCLES   (LOCK),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_start_raw(bs),
    .btn_stop_raw (bp),
    .btn_clear_raw(bc),
    .run_state    (rs),
    .start_o      (start_o),
    .stop_o       (stop_o),
    .clear_o      (clear_o),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int cmd;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   npulse = 0;
  int   cyc = 0;
  bit   exp_busy = 1'b0;

  // Reference model state: raw sample history per button (index 0 = newest), debounced level,
  // rise seen on the previous edge, lockout remaining and stop hold length.
  bit   hist[3][D+1];
  bit   lvl[3];
  bit   rise[3];
  int   lock_left = 0;
  int   hold = 0;

  always @(posedge clk) begin
    bit raw[3];
    bit lp, running, flip;
    int cmd;
    raw[0] = bs;
    raw[1] = bp;
    raw[2] = bc;
    cyc++;
    if (reset) begin
      for (int b = 0; b < 3; b++) begin
        for (int i = 0; i <= D; i++) hist[b][i] = 1'b0;
        lvl[b]  = 1'b0;
        rise[b] = 1'b0;
      end
      lock_left = 0;
      hold      = 0;
      exp_busy  = 1'b0;
    end else begin
      lp = 1'b0;
`ifdef LONG_PRESS_CLEAR_EN
      if (lvl[1]) begin
        if (hold < LONG) hold++;
        lp = (hold == LONG) && (hold_prev_below_long(hold));
      end else begin
        hold = 0;
      end
`endif
      running = (rs == 2'b01);
      cmd     = 0;
      if (lock_left == 0) begin
        if ((rise[2] || lp) && !running) cmd = 3;
        else if (rise[1] && running) cmd = 2;
        else if (rise[0] && !running) cmd = 1;
      end
      if (cmd != 0) begin
        exp_q.push_back('{cyc: cyc, cmd: cmd});
        lock_left = LOCK;
      end else if (lock_left > 0) begin
        lock_left--;
      end
      exp_busy = (lock_left > 0);
      // A level flips once the last D synchronised samples all disagree with it.
      for (int b = 0; b < 3; b++) begin
        flip = 1'b1;
        for (int i = 1; i <= D; i++) if (hist[b][i] == lvl[b]) flip = 1'b0;
        rise[b] = flip && !lvl[b];
        if (flip) lvl[b] = ~lvl[b];
        for (int i = D; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = raw[b];
      end
    end
  end

  // True only on the edge where the hold count has just reached LONG.
  bit lp_fired = 1'b0;
  function automatic bit hold_prev_below_long(input int h);
    bit r;
    r = (h == LONG) && !lp_fired;
    lp_fired = (h == LONG);
    return r;
  endfunction

  always @(posedge clk) if (reset || !lvl[1]) lp_fired <= 1'b0;

  always @(negedge clk) begin
    int got;
    if (cyc > 0) begin
      got = 0;
      if (start_o) got = 1;
      if (stop_o) got = 2;
      if (clear_o) got = 3;
      checks++;
      if ((int'(start_o) + int'(stop_o) + int'(clear_o)) > 1) begin
        errors++;
        $display("FAIL onehot cyc=%0d got start=%b stop=%b clear=%b required at most one",
                 cyc, start_o, stop_o, clear_o);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got %b required %b", cyc, busy, exp_busy);
      end
      if (got != 0) begin
        npulse++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d got cmd %0d required none", cyc, got);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.cmd != got || e.cyc != cyc) begin
            errors++;
            $display("FAIL pulse cyc=%0d got cmd %0d required cmd %0d at cyc %0d",
                     cyc, got, e.cmd, e.cyc);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        ev_t e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pulse cyc=%0d got none required cmd %0d", cyc, e.cmd);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic apply(input int m);
    bs = m[0];
    bp = m[1];
    bc = m[2];
  endtask

  initial begin
    int m1, m2, off, len, gap;
    tick(3);
    reset = 1'b0;
    // Idle, long start press: single start 18 edges after the first sample.
    rs = 2'b00;
    apply(1);
    tick(40);
    apply(0);
    tick(30);
    // Running, short stop glitch then a stable press.
    rs = 2'b01;
    apply(2);
    tick(10);
    apply(0);
    tick(30);
    apply(2);
    tick(20);
    apply(0);
    tick(30);
    // Paused, start and clear together.
    rs = 2'b10;
    apply(5);
    tick(25);
    apply(0);
    tick(30);
    for (int it = 0; it < 250; it++) begin
      rs  = 2'($urandom_range(0, 3));
      m1  = $urandom_range(1, 7);
      m2  = $urandom_range(0, 7);
      off = $urandom_range(0, 6);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, D - 1) : $urandom_range(D, 110);
      gap = $urandom_range(D + 4, 60);
      apply(m1);
      tick(off);
      apply(m1 | m2);
      if (it % 10 == 5) begin
        tick(len / 2);
        reset = 1'b1;
        tick($urandom_range(1, 3));
        reset = 1'b0;
        tick(len - len / 2);
      end else begin
        tick(len / 2);
        if ($urandom_range(0, 2) == 0) rs = 2'($urandom_range(0, 3));
        tick(len - len / 2);
      end
      apply(0);
      tick(gap);
    end
    tick(100);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending pulses required 0", exp_q.size());
    end
    checks++;
    if (npulse == 0) begin
      errors++;
      $display("FAIL activity got %0d pulses required more than 0", npulse);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
